// File: rtl/tick_scheduler_pkg.sv
// rtl/tick_scheduler_pkg.sv - default constants and channel state type for tick_scheduler
package tick_sched_pkg;
  localparam int TS_NUM_CH   = 4;
  localparam int TS_PRESCALE = 500;
  localparam int TS_CNT_W    = 16;

  typedef enum logic {TS_IDLE, TS_RUN} ts_state_e;
endpackage

// File: rtl/tick_scheduler_if.sv
// rtl/tick_scheduler_if.sv - request/timer bus between requesters and tick_scheduler
interface tick_scheduler_if import tick_sched_pkg::*; #(
  parameter int NUM_CH = TS_NUM_CH,
  parameter int CNT_W  = TS_CNT_W
);
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH*CNT_W-1:0] req_ticks;
  logic [NUM_CH-1:0]       req_ready;
  logic [NUM_CH-1:0]       cancel;
  logic                    tick;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       expire;

  modport master (
    output req_valid, req_ticks, cancel,
    input  req_ready, tick, busy, expire
  );

  modport slave (
    input  req_valid, req_ticks, cancel,
    output req_ready, tick, busy, expire
  );
endinterface

// File: rtl/tick_scheduler_rr_arbiter.sv
// rtl/tick_scheduler_rr_arbiter.sv - round-robin one-hot arbiter, pointer moves only on a grant
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         in_clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_idx;
  logic [IW:0]   w_pos;
  logic          w_any;

  // One extra bit on w_pos holds last+k before the modulo-N fold.
  always_comb begin
    gnt   = '0;
    w_idx = '0;
    w_pos = '0;
    w_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_pos = {1'b0, r_last} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(N)) begin
        w_pos = w_pos - (IW+1)'(N);
      end
      if (!w_any && req[w_pos[IW-1:0]]) begin
        gnt[w_pos[IW-1:0]] = 1'b1;
        w_idx              = w_pos[IW-1:0];
        w_any              = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      r_last <= IW'(N-1);
    end else if (w_any) begin
      r_last <= w_idx;
    end
  end
endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - shared prescaled tick plus per-channel countdown timeouts
module tick_scheduler import tick_sched_pkg::*; #(
  parameter int NUM_CH   = TS_NUM_CH,
  parameter int PRESCALE = TS_PRESCALE,
  parameter int CNT_W    = TS_CNT_W
) (
  input logic              in_clk,
  input logic              rst,
  tick_scheduler_if.slave  bus
);
  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0]     r_presc;
  logic              w_tick;
  logic [NUM_CH-1:0] w_cand;
  logic [NUM_CH-1:0] w_gnt;
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_expire;

  // Free-running: loads never realign the timebase.
  assign w_tick = (r_presc == PW'(PRESCALE - 1));

  always_ff @(posedge in_clk) begin
    if (rst || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign w_cand = bus.req_valid & ~bus.cancel;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .in_clk (in_clk),
    .rst    (rst),
    .req    (w_cand),
    .gnt    (w_gnt)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ts_state_e        r_state;
    logic [CNT_W-1:0] r_rem;
    logic             r_expire;
    logic [CNT_W-1:0] w_n;

    assign w_n = bus.req_ticks[i*CNT_W +: CNT_W];

    // Cancel beats load beats tick; a load on a tick cycle ignores that tick.
    always_ff @(posedge in_clk) begin
      if (rst) begin
        r_state  <= TS_IDLE;
        r_rem    <= '0;
        r_expire <= 1'b0;
      end else begin
        r_expire <= 1'b0;
        if (bus.cancel[i]) begin
          r_state <= TS_IDLE;
          r_rem   <= '0;
        end else if (w_gnt[i]) begin
          if (w_n == '0) begin
            r_state  <= TS_IDLE;
            r_rem    <= '0;
            r_expire <= 1'b1;
          end else begin
            r_state <= TS_RUN;
            r_rem   <= w_n;
          end
        end else if (r_state == TS_RUN && w_tick) begin
          if (r_rem <= CNT_W'(1)) begin
            r_state  <= TS_IDLE;
            r_rem    <= '0;
            r_expire <= 1'b1;
          end else begin
            r_rem <= r_rem - CNT_W'(1);
          end
        end
      end
    end

    assign w_busy[i]   = (r_state == TS_RUN);
    assign w_expire[i] = r_expire;
  end

  assign bus.req_ready = w_gnt;
  assign bus.tick      = w_tick;
  assign bus.busy      = w_busy;
  assign bus.expire    = w_expire;
endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - scoreboard bench for tick_scheduler against a deadline-based model
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int NC = TS_NUM_CH;
  localparam int P  = TS_PRESCALE;
  localparam int CW = TS_CNT_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tick_scheduler_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();

  tick_scheduler #(.NUM_CH(NC), .PRESCALE(P), .CNT_W(CW)) dut (
    .in_clk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    int            cyc;
    bit            full;
    logic [NC-1:0] ready;
    logic          tick;
    logic [NC-1:0] busy;
    logic [NC-1:0] expire;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_push = 0;
  int   n_pop  = 0;

  // Model: each channel is an absolute expiry cycle, derived from tick arithmetic.
  int m_cyc;
  int m_last;
  int m_exp[NC];
  bit m_run[NC];

  function automatic void chk(string nm, int cyc, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, req);
    end
  endfunction

  task automatic apply(input bit r, input logic [NC-1:0] v,
                       input logic [NC*CW-1:0] t, input logic [NC-1:0] c);
    exp_t          e;
    logic [NC-1:0] cand;
    int            g;
    int            n;
    rst           = r;
    bus.req_valid = v;
    bus.req_ticks = t;
    bus.cancel    = c;
    cand = v & ~c;
    g    = -1;
    for (int k = 1; k <= NC; k++) begin
      if (g < 0 && cand[(m_last + k) % NC]) g = (m_last + k) % NC;
    end
    e.cyc   = m_cyc;
    e.full  = !r;
    e.ready = '0;
    if (g >= 0) e.ready[g] = 1'b1;
    e.tick  = ((m_cyc % P) == P - 1);
    for (int i = 0; i < NC; i++) begin
      e.busy[i]   = m_run[i] && (m_cyc < m_exp[i]);
      e.expire[i] = (m_exp[i] == m_cyc);
    end
    sb.push_back(e);
    n_push++;
    if (r) begin
      m_last = NC - 1;
      m_cyc  = 0;
      for (int i = 0; i < NC; i++) begin
        m_exp[i] = -1;
        m_run[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (c[i]) begin
          if (m_exp[i] > m_cyc) begin
            m_exp[i] = -1;
            m_run[i] = 1'b0;
          end
        end else if (g == i) begin
          n = int'(t[i*CW +: CW]);
          if (n == 0) begin
            m_exp[i] = m_cyc + 1;
            m_run[i] = 1'b0;
          end else begin
            m_exp[i] = ((m_cyc + 1) / P + n) * P;
            m_run[i] = 1'b1;
          end
        end
      end
      if (g >= 0) m_last = g;
      m_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) apply(1'b1, '0, '0, '0);
  endtask

  task automatic run_to(input int target);
    while (m_cyc < target) apply(1'b0, '0, '0, '0);
  endtask

  task automatic load1(input int ch, input int n);
    logic [NC-1:0]    v;
    logic [NC*CW-1:0] t;
    v = '0;
    t = '0;
    v[ch] = 1'b1;
    t[ch*CW +: CW] = CW'(n);
    apply(1'b0, v, t, '0);
  endtask

  task automatic cancel1(input int ch);
    logic [NC-1:0] c;
    c = '0;
    c[ch] = 1'b1;
    apply(1'b0, '0, '0, c);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_pop++;
        chk("req_ready", e.cyc, 32'(bus.req_ready), 32'(e.ready));
        if (e.full) begin
          chk("tick", e.cyc, 32'(bus.tick), 32'(e.tick));
          chk("busy", e.cyc, 32'(bus.busy), 32'(e.busy));
          chk("expire", e.cyc, 32'(bus.expire), 32'(e.expire));
        end
      end
    end
  end

  initial begin : stim
    logic [NC-1:0]    v;
    logic [NC-1:0]    c;
    logic [NC*CW-1:0] t;
    bit               r;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_ticks = '0;
    bus.cancel    = '0;
    m_cyc  = 0;
    m_last = NC - 1;
    for (int i = 0; i < NC; i++) begin
      m_exp[i] = -1;
      m_run[i] = 1'b0;
    end
    @(posedge clk);
    #1;

    // Idle timebase: ticks at 499, 999, 1499 only.
    reset_cycles(2);
    run_to(1600);

    // Channel 1, N=3 at cycle 10 -> expire at 1500.
    reset_cycles(1);
    run_to(10);
    load1(1, 3);
    run_to(1600);

    // Round-robin order, with channel 0 loading N=0.
    reset_cycles(1);
    run_to(5);
    t = {CW'(2), CW'(2), CW'(2), CW'(0)};
    for (int i = 0; i < 4; i++) apply(1'b0, 4'hF, t, '0);
    for (int i = 0; i < 4; i++) apply(1'b0, 4'b0101, t, '0);
    run_to(1100);

    // Cancel on the final tick, reload on a tick, then reset with two running.
    reset_cycles(1);
    run_to(600);
    load1(3, 1);
    run_to(999);
    cancel1(3);
    run_to(1100);
    load1(3, 1);
    load1(2, 2);
    run_to(1499);
    load1(3, 5);
    run_to(1700);
    reset_cycles(1);
    run_to(1100);

    for (int cyc = 0; cyc < 30000; cyc++) begin
      r = ($urandom_range(0, 4999) == 0);
      for (int i = 0; i < NC; i++) begin
        v[i] = ($urandom_range(0, 7) == 0);
        c[i] = ($urandom_range(0, 63) == 0);
        t[i*CW +: CW] = CW'($urandom_range(0, 4));
      end
      apply(r, v, t, c);
    end

    apply(1'b0, '0, '0, '0);
    chk("sb_drain", 0, 32'(n_pop), 32'(n_push));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shared timebase and timeout scheduler. A free-running prescaler generates a one-cycle `tick` every `PRESCALE` clocks, matching the 500-cycle period of the system slow-clock divider. `NUM_CH` requesters share that tick through per-channel countdown timers; load requests are arbitrated round-robin, one per cycle. Sits between the clock divider domain logic and the control blocks that need coarse timeouts (debounce, watchdog, retry delays).

## Interface
- `NUM_CH`, 4, number of requester channels (2..8)
- `PRESCALE`, 500, clocks per tick (>= 2)
- `CNT_W`, 16, width of the tick count per request

- `in_clk`  in  1  system clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_CH  per-channel load request
- `req_ticks`  in  NUM_CH*CNT_W  tick count per channel; channel i uses bits [i*CNT_W +: CNT_W]
- `req_ready`  out  NUM_CH  one-hot combinational grant; load transfers when `req_valid[i] && req_ready[i]`
- `cancel`  in  NUM_CH  per-channel timer clear
- `tick`  out  1  one-cycle timebase pulse
- `busy`  out  NUM_CH  channel timer running
- `expire`  out  NUM_CH  one-cycle pulse on timeout

## Operation
- Prescaler: `presc` counts 0..PRESCALE-1, wraps to 0. `tick = (presc == PRESCALE-1)`. It runs freely and is never restarted by loads.
- Arbitration: candidates are `req_valid & ~cancel`. Round-robin search starts at `last+1` mod NUM_CH. `req_ready` has at most one bit set. `last` updates to the granted index only on a grant.
- Per-channel state is IDLE or RUN, with `rem` (CNT_W bits).
- Load accepted, N == 0: `expire[i]` pulses next cycle; state becomes IDLE.
- Load accepted, N > 0: state becomes RUN and `rem` is set to N. This applies in IDLE or RUN (reload restarts the timer; the pending expiry is dropped).
- RUN with `tick`: if `rem == 1`, state becomes IDLE, `rem` becomes 0, and `expire[i]` pulses next cycle. Otherwise `rem` decrements by 1.
- `cancel[i]`: state becomes IDLE and `rem` becomes 0. No expire.
- Priority per channel, same cycle: cancel > load > tick-decrement. A load on a tick cycle ignores that tick. Cancel on the final tick suppresses the expire.
- `busy[i] = (state == RUN)`.
- Arithmetic: `rem` never underflows. Decrement occurs only when `rem >= 1` in RUN.

## Timing
- Reset values: `presc = 0`, `last = NUM_CH-1` (channel 0 has first priority), all channels IDLE with `rem = 0`.
- Output reset values: `tick = 0`, `busy = 0`, `expire = 0`. `req_ready` follows `req_valid` combinationally, even during the reset cycle; loads in a reset cycle are discarded.
- First `tick` occurs in cycle PRESCALE-1 after reset release (cycle 0 is the first non-reset cycle). Subsequent ticks are every PRESCALE cycles.
- Load accepted in cycle c sets `busy` in c+1.
- `expire` is asserted in the cycle after the Nth tick strictly after c. Timeout = (N-1)*PRESCALE + 1 .. N*PRESCALE cycles, depending on phase.
- `expire` and the `busy` fall occur in the same cycle.
- `expire` on several channels in one cycle is legal.
- Reset mid-operation: all timers are dropped with no expire. Behaviour is identical to power-up.
- A requester holding `req_valid` waits at most NUM_CH-1 cycles for a grant.

## Structure
- Package `tick_sched_pkg`:
  - default constants: `TS_NUM_CH = 4`, `TS_PRESCALE = 500`, `TS_CNT_W = 16`
  - `typedef enum logic {TS_IDLE, TS_RUN} ts_state_e`
- Sub-module `rr_arbiter`, parameter N:
  - inputs: `in_clk`, `rst`, `req[N]`
  - output: one-hot `gnt[N]`
  - internal pointer updates on any grant
- Per-channel timers are a generate loop in the top module.

## Test plan
- Reset, idle, PRESCALE=500 -> `tick` high in cycles 499, 999, 1499 only. `busy = 0`, `expire = 0` throughout.
- Channel 1 loads N=3 at cycle 10 -> `busy[1]` set at cycle 11. `expire[1]` pulses at cycle 1500 (after the tick at 1499). `busy[1]` drops at cycle 1500.
- All four channels hold `req_valid` from cycle 5 -> grants go 0,1,2,3 in cycles 5-8. Then hold channel 2 and channel 0 only -> grants alternate 0,2,0,2.
- Channel 0 loads N=0 -> `expire[0]` pulses the next cycle. `busy[0]` never rises.
- Channel 3 running with `rem = 1`; `cancel[3]` asserted on the tick cycle -> no expire; `busy[3]` falls next cycle. Separately, a reload N=5 on the tick cycle -> `rem = 5` and the tick is ignored.
- `rst` asserted with two channels running -> next cycle `busy = 0`, no expire, `presc` restarts. The first tick after release is PRESCALE-1 cycles later.
